viterbi_frame_ctrl: RTL and testbench

Frame-level sequencer for the convolutional encoder -> channel -> Viterbi decoder test chain. On a start request it drives one frame of LFSR pseudo-random payload bits plus zero tail bits into the encoder. It also issues a burst error-injection mask to the channel. It compares the decoder output against a latency-aligned copy of the sent bits and reports bit-error and injection counts with a done pulse.

---
 rtl/viterbi_frame_ctrl.sv | 178 +++++++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the encoder -> channel -> Viterbi decoder test chain.
// Latency: every output is registered; decoder_i is compared DEC_LAT cycles after its payload bit leaves.
// Backpressure: none; start_i is honoured only in IDLE, otherwise dropped (never queued).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             frame request (IDLE only)
//   inj_en_i            error-injection enable, latched at start accept
//   decoder_i           decoded bit returned by the Viterbi decoder
//   encoder_i_o         payload/tail bit to the encoder
//   enable_encoder_o    encoder enable (payload + tail cycles)
//   err_inj_o           channel XOR mask for the current encoder bit
//   busy_o / done_o     frame in flight / one-cycle end-of-frame pulse
//   bit_err_ct_o        decoded-bit mismatches this frame (saturating)
//   inj_ct_o            injected cycles this frame (saturating)
`timescale 1ns/1ps
module viterbi_frame_ctrl #(
    parameter int          FRAME_LEN    = 256,
    parameter int          TAIL_LEN     = 2,
    parameter int          DEC_LAT      = 24,
    parameter int          BURST_LEN    = 5,
    parameter int          BURST_PERIOD = 32,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        inj_en_i,
    input  logic        decoder_i,
    output logic        encoder_i_o,
    output logic        enable_encoder_o,
    output logic [1:0]  err_inj_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bit_err_ct_o,
    output logic [15:0] inj_ct_o
);

    typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_TAIL, S_DRAIN, S_DONE} state_t;

    localparam logic [15:0] FRAME_LEN16 = 16'(FRAME_LEN);
    localparam logic [15:0] FRAME_LAST  = 16'(FRAME_LEN - 1);
    localparam logic [15:0] TAIL_LAST   = 16'(TAIL_LEN - 1);
    localparam logic [15:0] PERIOD_MASK = 16'(BURST_PERIOD - 1);
    localparam logic [15:0] BURST_START = 16'(BURST_PERIOD - BURST_LEN);
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;        // index within PAYLOAD or TAIL
    logic [15:0]         lfsr_q, lfsr_d;
    logic                inj_en_q, inj_en_d;
    logic [15:0]         cmp_q, cmp_d;        // payload bits compared so far
    logic [15:0]         bit_err_q, bit_err_d;
    logic [15:0]         inj_ct_q, inj_ct_d;
    logic                enc_q, enc_d;
    logic                en_q, en_d;
    logic [1:0]          inj_q, inj_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DEC_LAT-1:0]  ref_bit_q, ref_vld_q;
    logic                accept;
    logic                tap_vld, tap_bit;

    // Oldest delay-line slot holds the bit driven exactly DEC_LAT cycles ago.
    assign tap_vld = ref_vld_q[DEC_LAT-1];
    assign tap_bit = ref_bit_q[DEC_LAT-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        inj_en_d  = inj_en_q;
        cmp_d     = cmp_q;
        bit_err_d = bit_err_q;
        inj_ct_d  = inj_ct_q;
        accept    = (state_q == S_IDLE) && start_i;

        if (accept) begin
            cmp_d     = '0;
            bit_err_d = '0;
            inj_ct_d  = '0;
        end else begin
            if (tap_vld) begin
                cmp_d = cmp_q + 16'd1;
                if ((decoder_i != tap_bit) && (bit_err_q != CNT_MAX))
                    bit_err_d = bit_err_q + 16'd1;
            end
            if ((inj_q != 2'b00) && (inj_ct_q != CNT_MAX))
                inj_ct_d = inj_ct_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_PAYLOAD;
                    cnt_d    = '0;
                    inj_en_d = inj_en_i;
                end
            end
            S_PAYLOAD: begin
                // Fibonacci x^16+x^14+x^13+x^11+1, shifting toward bit 0.
                lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                if (cnt_q == FRAME_LAST) begin
                    cnt_d   = '0;
                    state_d = (TAIL_LEN == 0) ? S_DRAIN : S_TAIL;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DRAIN: begin
                if (cmp_d == FRAME_LEN16)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        en_d   = (state_d == S_PAYLOAD) || (state_d == S_TAIL);
        enc_d  = (state_d == S_PAYLOAD) && lfsr_d[0];
        busy_d = (state_d == S_PAYLOAD) || (state_d == S_TAIL) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        inj_d  = ((state_d == S_PAYLOAD) && inj_en_d && ((cnt_d & PERIOD_MASK) >= BURST_START))
                 ? 2'b01 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            inj_en_q  <= 1'b0;
            cmp_q     <= '0;
            bit_err_q <= '0;
            inj_ct_q  <= '0;
            enc_q     <= 1'b0;
            en_q      <= 1'b0;
            inj_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ref_bit_q <= '0;
            ref_vld_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            inj_en_q  <= inj_en_d;
            cmp_q     <= cmp_d;
            bit_err_q <= bit_err_d;
            inj_ct_q  <= inj_ct_d;
            enc_q     <= enc_d;
            en_q      <= en_d;
            inj_q     <= inj_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            // Push the bit currently on encoder_i_o; only payload bits are marked valid.
            ref_bit_q <= DEC_LAT'({ref_bit_q, enc_q});
            ref_vld_q <= DEC_LAT'({ref_vld_q, (state_q == S_PAYLOAD)});
        end
    end

    assign encoder_i_o      = enc_q;
    assign enable_encoder_o = en_q;
    assign err_inj_o        = inj_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign bit_err_ct_o     = bit_err_q;
    assign inj_ct_o         = inj_ct_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl with an ideal decoder (encoder bit delayed DEC_LAT).
// Latency: frame checks use accept cycle a -> done at a+281 for the default parameters.
// Backpressure: start pulses during busy/done must be ignored.
`timescale 1ns/1ps
module tb_viterbi_frame_ctrl;

    localparam int FL = 256;
    localparam int TL = 2;
    localparam int DL = 24;
    localparam int BL = 5;
    localparam int BP = 32;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        inj_en_i;
    logic        decoder_i;
    logic        encoder_i_o;
    logic        enable_encoder_o;
    logic [1:0]  err_inj_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] bit_err_ct_o;
    logic [15:0] inj_ct_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit       log_enc  [0:8191];
    bit       log_en   [0:8191];
    bit       log_busy [0:8191];
    bit       log_done [0:8191];
    bit [1:0] log_inj  [0:8191];
    bit       flip     [0:8191];

    logic [15:0] lfsr_m;

    viterbi_frame_ctrl #(
        .FRAME_LEN(FL), .TAIL_LEN(TL), .DEC_LAT(DL),
        .BURST_LEN(BL), .BURST_PERIOD(BP), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .inj_en_i(inj_en_i),
        .decoder_i(decoder_i),
        .encoder_i_o(encoder_i_o),
        .enable_encoder_o(enable_encoder_o),
        .err_inj_o(err_inj_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .bit_err_ct_o(bit_err_ct_o),
        .inj_ct_o(inj_ct_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ix(input int c);
        return c & 8191;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic inj, output int a);
        start_i  = 1'b1;
        inj_en_i = inj;
        a        = cyc;
        tick();
        start_i  = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int d);
        d = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (done_o === 1'b1) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) chk("done_timeout", 0, 1);
    endtask

    // Walks the logged cycles a+1..d against the frame timeline and the LFSR model.
    task automatic check_frame(input string tag, input int a, input int d, input logic inj,
                               input int exp_err, input logic seed16);
        int          enc_bad, en_bad, inj_bad, bsy_bad, dn_bad, k;
        logic [15:0] w;
        logic        exp_enc;
        logic [1:0]  exp_inj;
        enc_bad = 0; en_bad = 0; inj_bad = 0; bsy_bad = 0; dn_bad = 0; w = '0;
        if (d < 0) return;
        chk({tag, "_latency"}, d - a, 281);
        for (int c = a + 1; c <= d; c++) begin
            k       = c - a - 1;
            exp_enc = 1'b0;
            if (k < FL) begin
                exp_enc = lfsr_m[0];
                if (k < 16) w[k] = log_enc[ix(c)];
                lfsr_m = lfsr_step(lfsr_m);
            end
            exp_inj = ((k < FL) && inj && ((k % BP) >= (BP - BL))) ? 2'b01 : 2'b00;
            if (log_enc[ix(c)]  != exp_enc)       enc_bad++;
            if (log_en[ix(c)]   != (k < FL + TL)) en_bad++;
            if (log_inj[ix(c)]  != exp_inj)       inj_bad++;
            if (log_busy[ix(c)] != (c < d))       bsy_bad++;
            if (log_done[ix(c)] != (c == d))      dn_bad++;
        end
        chk({tag, "_enc_bits"}, enc_bad, 0);
        chk({tag, "_enable"},   en_bad,  0);
        chk({tag, "_inj_mask"}, inj_bad, 0);
        chk({tag, "_busy"},     bsy_bad, 0);
        chk({tag, "_done"},     dn_bad,  0);
        if (seed16) chk({tag, "_first16"}, w, 16'hACE1);
        chk({tag, "_bit_err"}, bit_err_ct_o, exp_err);
        chk({tag, "_inj_ct"},  inj_ct_o, inj ? 40 : 0);
    endtask

    // Per-cycle log of DUT outputs, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            log_enc[ix(cyc)]  = encoder_i_o;
            log_en[ix(cyc)]   = enable_encoder_o;
            log_inj[ix(cyc)]  = err_inj_o;
            log_busy[ix(cyc)] = busy_o;
            log_done[ix(cyc)] = done_o;
        end
    end

    // Ideal decoder: returns the encoder bit from DL cycles earlier, optionally inverted.
    initial begin
        decoder_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            decoder_i = ((cyc >= DL) ? log_enc[ix(cyc - DL)] : 1'b0) ^ flip[ix(cyc)];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, d, d4, n, m;
        rst = 1'b1; start_i = 1'b0; inj_en_i = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_enc",     encoder_i_o,      0);
        chk("rst_en",      enable_encoder_o, 0);
        chk("rst_inj",     err_inj_o,        0);
        chk("rst_busy",    busy_o,           0);
        chk("rst_done",    done_o,           0);
        chk("rst_bit_err", bit_err_ct_o,     0);
        chk("rst_inj_ct",  inj_ct_o,         0);
        lfsr_m = 16'hACE1;

        // Clean frame, then injected frame continuing the LFSR sequence.
        tick(); start_frame(1'b0, a); wait_done(400, d);
        check_frame("f1", a, d, 1'b0, 0, 1'b1);
        tick(); start_frame(1'b1, a); wait_done(400, d);
        check_frame("f2", a, d, 1'b1, 0, 1'b0);

        // Decoder inversions: three on valid taps, two before the first valid tap.
        tick(); a = cyc;
        flip[ix(a + 10)]  = 1'b1;
        flip[ix(a + 24)]  = 1'b1;
        flip[ix(a + 25)]  = 1'b1;
        flip[ix(a + 125)] = 1'b1;
        flip[ix(a + 280)] = 1'b1;
        start_frame(1'b0, a);
        repeat (49) tick();
        start_i = 1'b1; tick(); start_i = 1'b0;
        wait_done(400, d);
        start_i = 1'b1;
        check_frame("f3", a, d, 1'b0, 3, 1'b0);
        tick(); start_i = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk); #1;
            n += int'(busy_o) + int'(enable_encoder_o);
        end
        chk("f3_done_start_ignored", n, 0);
        chk("f3_err_hold", bit_err_ct_o, 3);

        // start_i held high: back-to-back frames, counters cleared at the second accept.
        tick(); a = cyc;
        flip[ix(a + 30)] = 1'b1;
        start_i = 1'b1; inj_en_i = 1'b1;
        tick();
        wait_done(400, d);
        inj_en_i = 1'b0;
        check_frame("f4", a, d, 1'b1, 1, 1'b0);
        d4 = d;
        tick();
        @(negedge clk); #1;
        chk("b2b_idle_gap", enable_encoder_o, 0);
        chk("b2b_cnt_hold", bit_err_ct_o, 1);
        tick();
        start_i = 1'b0; inj_en_i = 1'b1;
        @(negedge clk); #1;
        chk("b2b_payload", enable_encoder_o, 1);
        chk("b2b_err_clr", bit_err_ct_o, 0);
        chk("b2b_inj_clr", inj_ct_o, 0);
        wait_done(400, d);
        check_frame("f5", d4 + 1, d, 1'b0, 0, 1'b0);

        // Reset at payload index 100 abandons the frame.
        tick(); start_frame(1'b1, a);
        repeat (100) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk); #1;
        chk("midrst_ctl", {encoder_i_o, enable_encoder_o, err_inj_o, busy_o, done_o}, 0);
        chk("midrst_cnt", {bit_err_ct_o, inj_ct_o}, 0);
        n = 0; m = 0;
        repeat (320) begin
            @(negedge clk); #1;
            n += int'(done_o);
            m += int'(busy_o);
        end
        chk("midrst_no_done", n, 0);
        chk("midrst_idle", m, 0);
        lfsr_m = 16'hACE1;
        tick(); start_frame(1'b0, a); wait_done(400, d);
        check_frame("f7", a, d, 1'b0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
